bcd_seq_add_ctrl: RTL and testbench

BCD_SEQ_ADD_CTRL -- requirements
Module: bcd_seq_add_ctrl

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_seq_add_ctrl.sv | 121 ++++++++++++
 tb/tb_bcd_seq_add_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with decimal-correct carry and invalid-digit flag.
// Latency: combinational; no flow control.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       inv
);

  logic [4:0] bin_sum;
  logic       gt9;

  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    gt9     = bin_sum[4] | (bin_sum[3] & bin_sum[2]) | (bin_sum[3] & bin_sum[1]);
    s       = gt9 ? (bin_sum[3:0] + BCD_CORR) : bin_sum[3:0];
    co      = gt9;
    inv     = (a > BCD_MAX) | (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_seq_add_ctrl.sv
// Serial NDIG-digit BCD adder, one digit per clock LSD first; done NDIG+1 cycles after start.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
module bcd_seq_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int IW = $clog2(NDIG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  bcd_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] a_q, a_d;
  logic [4*NDIG-1:0] b_q, b_d;
  logic [4*NDIG-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [3:0] dig_s;
  logic       dig_co;
  logic       dig_inv;

  // Operand registers shift right, so the adder always sees digit 0.
  bcd_digit_add u_digit (
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .ci  (carry_q),
    .s   (dig_s),
    .co  (dig_co),
    .inv (dig_inv)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        sum_d[4*int'(idx_q) +: 4] = dig_s;
        carry_d = dig_co;
        err_d   = err_q | dig_inv;
        a_d     = {4'b0, a_q[4*NDIG-1:4]};
        b_d     = {4'b0, b_q[4*NDIG-1:4]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cout_d  = dig_co;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_add_ctrl.sv
// Randomized and directed bench for the serial BCD adder against a decimal-arithmetic model.
module tb_bcd_seq_add_ctrl;

  localparam int NDIG = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
  logic              cin;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] sum;
  logic              cout;
  logic              err;

  int n_total;
  int n_pass;

  logic [31:0] last_sum;
  logic        last_cout;

  bcd_seq_add_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Decimal reference: operands read as base-10 numbers, added, re-encoded.
  function automatic void ref_add(input logic [31:0] ra, input logic [31:0] rb, input logic rc,
                                  output logic [31:0] rs, output logic rco, output logic re);
    longint va, vb, r;
    logic [31:0] ta, tb;
    va = 0; vb = 0; re = 1'b0; ta = ra; tb = rb;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (ta[4*i +: 4] > 4'd9 || tb[4*i +: 4] > 4'd9) re = 1'b1;
      va = va * 10 + longint'(ta[4*i +: 4]);
      vb = vb * 10 + longint'(tb[4*i +: 4]);
    end
    r   = va + vb + longint'(rc);
    rco = (r >= 64'd100000000);
    r   = r % 100000000;
    rs  = '0;
    for (int i = 0; i < NDIG; i++) begin
      rs[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Start one operation; the accepting edge is the next rising edge.
  // disturb: change operands and pulse start mid-run.
  task automatic do_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                       input logic oc, input bit keep_start, input bit disturb);
    logic [31:0] es;
    logic        ec, ee;
    ref_add(oa, ob, oc, es, ec, ee);
    a = oa; b = ob; cin = oc; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
    start = keep_start;
    for (int k = 1; k <= NDIG; k++) begin
      if (disturb && k == 3) begin
        a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom_range(0, 1)); start = 1'b1;
      end
      if (disturb && k == 4) start = keep_start;
      @(posedge clk); #1;
      if (k < NDIG) begin
        if (done !== 1'b0 || busy !== 1'b1)
          chk({tag, ".run_busy_done"}, {30'd0, busy, done}, 32'b10);
      end else begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'(ee));
        if (!ee) begin
          chk({tag, ".sum"}, sum, es);
          chk({tag, ".cout"}, 32'(cout), 32'(ec));
          last_sum = es;
          last_cout = ec;
        end
      end
    end
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    #3;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", sum, 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    do_op("dir1", 32'h12345678, 32'h87654321, 1'b0, 1'b0, 1'b0);
    do_op("dir2", 32'h99999999, 32'h00000000, 1'b1, 1'b0, 1'b0);
    do_op("dir3", 32'h00000058, 32'h00000067, 1'b0, 1'b0, 1'b1);
    do_op("err", 32'h0000000A, 32'h00000000, 1'b0, 1'b0, 1'b0);
    do_op("clr", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      do_op("b2b", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), (i < 5), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("idle.done", 32'(done), 32'd0);
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.sum", sum, last_sum);
    chk("idle.cout", 32'(cout), 32'(last_cout));

    for (int i = 0; i < 6; i++)
      do_op("rnd", rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'b0, (i % 2) == 1);

    do_op("pre_rst", 32'h99999999, 32'h00000000, 1'b1, 1'b0, 1'b0);
    a = 32'h11111111; b = 32'h11111111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", 32'(busy), 32'd0);
    chk("mid_rst.done", 32'(done), 32'd0);
    chk("mid_rst.sum", sum, 32'd0);
    chk("mid_rst.cout", 32'(cout), 32'd0);
    chk("mid_rst.err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("post_rst", rand_bcd(), rand_bcd(), 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
